// File: rtl/rtc_burst_reader.sv
// Read sequencer for the RTC register bus: fetches a list of time/date fields
// into a shadow bank and commits them atomically to the field output bank.
module rtc_burst_reader #(
    parameter int unsigned NUM_FIELDS = 6,
    parameter int unsigned TMR_FIELDS = 3,
    parameter logic [7:0]  CMD_CLK    = 8'hF1,
    parameter logic [7:0]  CMD_TMR    = 8'hF2,
    parameter logic [7:0]  CMD_DATA   = 8'h01,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF,
    parameter bit          BCD_CHECK  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    timer_mode,
    input  logic                    abort,
    input  logic [NUM_FIELDS*8-1:0] addr_tbl,
    input  logic                    dir_phase,
    input  logic                    dat_phase,
    input  logic                    step,
    input  logic [7:0]              rd_data,
    output logic                    bus_req,
    output logic [7:0]              bus_out,
    output logic [NUM_FIELDS*8-1:0] fields,
    output logic                    busy,
    output logic                    done,
    output logic                    bcd_err
);

    localparam int unsigned IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned TMR_EFF = (TMR_FIELDS < NUM_FIELDS) ? TMR_FIELDS : NUM_FIELDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_FIELD,
        S_COMMIT
    } state_t;

    state_t                         state_q, state_n;
    logic [IDX_W-1:0]               idx_q, idx_n;
    logic [IDX_W-1:0]               last_q, last_n;
    logic                           mode_q, mode_n;
    logic                           err_q, err_n;
    logic [NUM_FIELDS-1:0][7:0]     shadow_q, shadow_n;
    logic [NUM_FIELDS-1:0][7:0]     fields_q, fields_n;
    logic [NUM_FIELDS-1:0][7:0]     addr_arr;
    logic                           bus_req_q, bus_req_n;
    logic [7:0]                     bus_out_q, bus_out_n;
    logic                           busy_q, busy_n;
    logic                           done_q, done_n;
    logic                           bcd_err_q, bcd_err_n;
    logic                           dir_act, dat_act, step_act;

    function automatic logic bcd_bad(input logic [7:0] d);
        return BCD_CHECK && ((d[7:4] > 4'd9) || (d[3:0] > 4'd9));
    endfunction

    assign addr_arr = addr_tbl;

    // Only the highest-priority strobe acts in a cycle.
    assign dir_act  = dir_phase;
    assign dat_act  = dat_phase & ~dir_phase;
    assign step_act = step & ~dir_phase & ~dat_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            shadow_q  <= '0;
            fields_q  <= '0;
            bus_req_q <= 1'b0;
            bus_out_q <= IDLE_BYTE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            last_q    <= last_n;
            mode_q    <= mode_n;
            err_q     <= err_n;
            shadow_q  <= shadow_n;
            fields_q  <= fields_n;
            bus_req_q <= bus_req_n;
            bus_out_q <= bus_out_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            bcd_err_q <= bcd_err_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        last_n    = last_q;
        mode_n    = mode_q;
        err_n     = err_q;
        shadow_n  = shadow_q;
        fields_n  = fields_q;
        bus_req_n = bus_req_q;
        bus_out_n = bus_out_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        bcd_err_n = bcd_err_q;

        case (state_q)
            S_IDLE: begin
                bus_out_n = IDLE_BYTE;
                bus_req_n = 1'b0;
                if (start) begin
                    state_n   = S_CMD;
                    busy_n    = 1'b1;
                    bus_req_n = 1'b1;
                    mode_n    = timer_mode;
                    last_n    = timer_mode ? IDX_W'(TMR_EFF - 1) : IDX_W'(NUM_FIELDS - 1);
                    err_n     = 1'b0;
                    idx_n     = '0;
                end
            end
            S_CMD: begin
                bus_req_n = ~step_act;
                if (dir_act) begin
                    bus_out_n = mode_q ? CMD_TMR : CMD_CLK;
                end else if (dat_act) begin
                    bus_out_n = CMD_DATA;
                end else if (step_act) begin
                    idx_n   = '0;
                    state_n = S_FIELD;
                end
            end
            S_FIELD: begin
                bus_req_n = ~step_act;
                if (dir_act) begin
                    bus_out_n = addr_arr[idx_q];
                end else if (dat_act) begin
                    shadow_n[idx_q] = rd_data;
                    err_n           = err_q | bcd_bad(rd_data);
                end else if (step_act) begin
                    if (idx_q == last_q) begin
                        state_n = S_COMMIT;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                // Fields beyond the burst length keep their previous values.
                for (int i = 0; i < int'(NUM_FIELDS); i++) begin
                    if (i <= int'(last_q)) begin
                        fields_n[i] = shadow_q[i];
                    end
                end
                bcd_err_n = err_q;
                done_n    = 1'b1;
                busy_n    = 1'b0;
                bus_req_n = 1'b0;
                bus_out_n = IDLE_BYTE;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_n   = S_IDLE;
            bus_req_n = 1'b0;
            busy_n    = 1'b0;
            bus_out_n = IDLE_BYTE;
            done_n    = 1'b0;
            shadow_n  = shadow_q;
            fields_n  = fields_q;
            bcd_err_n = bcd_err_q;
        end
    end

    assign bus_req = bus_req_q;
    assign bus_out = bus_out_q;
    assign fields  = fields_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_rtc_burst_reader.sv
// Directed bench for rtc_burst_reader: clock/timer bursts, abort, BCD check,
// strobe collision and asynchronous reset, checked with immediate assertions.
module tb_rtc_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        timer_mode;
    logic        abort;
    logic [47:0] addr_tbl;
    logic        dir_phase;
    logic        dat_phase;
    logic        step;
    logic [7:0]  rd_data;
    logic        bus_req;
    logic [7:0]  bus_out;
    logic [47:0] fields;
    logic        busy;
    logic        done;
    logic        bcd_err;

    int tests = 0;
    int fails = 0;

    rtc_burst_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .timer_mode (timer_mode),
        .abort      (abort),
        .addr_tbl   (addr_tbl),
        .dir_phase  (dir_phase),
        .dat_phase  (dat_phase),
        .step       (step),
        .rd_data    (rd_data),
        .bus_req    (bus_req),
        .bus_out    (bus_out),
        .fields     (fields),
        .busy       (busy),
        .done       (done),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit d, input bit a, input bit s, input logic [7:0] rd);
        dir_phase = d;
        dat_phase = a;
        step      = s;
        rd_data   = rd;
        tick();
        dir_phase = 1'b0;
        dat_phase = 1'b0;
        step      = 1'b0;
    endtask

    task automatic cmd_phase(input bit tm, input logic [7:0] exp_cmd);
        timer_mode = tm;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_req", 64'(bus_req), 64'd1);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        chk("cmd_byte", 64'(bus_out), 64'(exp_cmd));
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        chk("cmd_data", 64'(bus_out), 64'h01);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("cmd_step_req", 64'(bus_req), 64'd0);
    endtask

    task automatic field_xfer(input logic [7:0] exp_addr, input logic [7:0] rd);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        chk("field_addr", 64'(bus_out), 64'(exp_addr));
        chk("field_req", 64'(bus_req), 64'd1);
        strobe(1'b0, 1'b1, 1'b0, rd);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        chk("field_step_req", 64'(bus_req), 64'd0);
    endtask

    task automatic burst(input bit tm, input int n, input logic [63:0] dv);
        cmd_phase(tm, tm ? 8'hF2 : 8'hF1);
        for (int i = 0; i < n; i++) begin
            field_xfer(8'(8'h21 + i), dv[8*i +: 8]);
        end
        chk("busy_before_commit", 64'(busy), 64'd1);
        tick();
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
        chk("idle_bus_out", 64'(bus_out), 64'hFF);
        tick();
        chk("done_single", 64'(done), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        timer_mode = 1'b0;
        abort      = 1'b0;
        addr_tbl   = 48'h26_25_24_23_22_21;
        dir_phase  = 1'b0;
        dat_phase  = 1'b0;
        step       = 1'b0;
        rd_data    = 8'h00;
        #12;
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_out", 64'(bus_out), 64'hFF);
        chk("rst_fields", 64'(fields), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd_err", 64'(bcd_err), 64'd0);
        reset = 1'b0;
        tick();

        // Strobes in IDLE are ignored.
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        chk("idle_strobe_ignored", 64'(bus_out), 64'hFF);

        // Full clock-mode burst.
        burst(1'b0, 6, 64'h0000_1615_1413_1211);
        chk("clk_fields", 64'(fields), 64'h1615_1413_1211);
        chk("clk_bcd_err", 64'(bcd_err), 64'd0);

        // Timer burst touches only the first three fields.
        burst(1'b1, 3, 64'h0000_0000_0033_3231);
        chk("tmr_fields", 64'(fields), 64'h1615_1433_3231);

        // Abort after the field 2 data phase.
        cmd_phase(1'b0, 8'hF1);
        field_xfer(8'h21, 8'h91);
        field_xfer(8'h22, 8'h92);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h93);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_req", 64'(bus_req), 64'd0);
        chk("abort_bus_out", 64'(bus_out), 64'hFF);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_fields", 64'(fields), 64'h1615_1433_3231);
        tick();
        chk("abort_no_done", 64'(done), 64'd0);
        burst(1'b0, 6, 64'h0000_4645_4443_4241);
        chk("post_abort_fields", 64'(fields), 64'h4645_4443_4241);

        // Non-BCD byte in field 1.
        burst(1'b0, 6, 64'h0000_5554_5352_5A50);
        chk("bcd_err_set", 64'(bcd_err), 64'd1);
        chk("bcd_fields", 64'(fields), 64'h5554_5352_5A50);
        burst(1'b0, 6, 64'h0000_6665_6463_6261);
        chk("bcd_err_clear", 64'(bcd_err), 64'd0);

        // All strobes together: only the address load acts; start while busy ignored.
        cmd_phase(1'b0, 8'hF1);
        strobe(1'b1, 1'b1, 1'b1, 8'h77);
        chk("coll_addr", 64'(bus_out), 64'h21);
        chk("coll_req", 64'(bus_req), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", 64'(busy), 64'd1);
        strobe(1'b0, 1'b1, 1'b0, 8'h71);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i < 6; i++) begin
            field_xfer(8'(8'h21 + i), 8'(8'h71 + i));
        end
        tick();
        chk("coll_done", 64'(done), 64'd1);
        chk("coll_fields", 64'(fields), 64'h7675_7473_7271);
        tick();
        tick();
        chk("coll_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset in FIELD idx 3.
        cmd_phase(1'b0, 8'hF1);
        field_xfer(8'h21, 8'h01);
        field_xfer(8'h22, 8'h02);
        field_xfer(8'h23, 8'h03);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_reset_addr", 64'(bus_out), 64'h24);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_fields", 64'(fields), 64'd0);
        chk("arst_bus_out", 64'(bus_out), 64'hFF);
        chk("arst_bus_req", 64'(bus_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_bcd_err", 64'(bcd_err), 64'd0);
        tick();
        reset = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_reset_idle", 64'(bus_out), 64'hFF);
        burst(1'b0, 6, 64'h0000_1615_1413_1211);
        chk("post_reset_fields", 64'(fields), 64'h1615_1413_1211);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_burst_reader.md
# rtc_burst_reader

Parametrised read sequencer for the RTC register bus. It fetches a configurable list of time/date fields from the RTC and commits them atomically to a field output bank. It sits between the top-level RTC controller, which issues `start`, and the bus driver, which generates address/data phase strobes and returns read bytes. It replaces the fixed six-field reader and adds:
- a timer/clock mode with a shorter field list
- shadow-buffered atomic update
- an abort input
- BCD validation
- a done pulse

## Interface
Parameters:
- `NUM_FIELDS`, 6: fields read in clock mode, 1..8. Field i uses address `addr_tbl[8i+7:8i]` and output `fields[8i+7:8i]`.
- `TMR_FIELDS`, 3: fields read in timer mode. Effective count is min(TMR_FIELDS, NUM_FIELDS).
- `CMD_CLK`, 8'hF1: transfer command byte, clock mode.
- `CMD_TMR`, 8'hF2: transfer command byte, timer mode.
- `CMD_DATA`, 8'h01: data byte of the command phase.
- `IDLE_BYTE`, 8'hFF: `bus_out` value while idle.
- `BCD_CHECK`, 1: 1 enables the BCD validation of captured bytes.

Ports:
- `clk` input 1: system clock, rising edge. This is the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a read burst. Sampled only in IDLE.
- `timer_mode` input 1: selects timer mode. Latched when `start` is accepted.
- `abort` input 1: abandon the burst and return to IDLE without committing.
- `addr_tbl` input NUM_FIELDS*8: RTC register address of each field.
- `dir_phase` input 1: bus driver strobe, address phase active.
- `dat_phase` input 1: bus driver strobe, data phase active and `rd_data` valid.
- `step` input 1: bus driver strobe, current transfer complete.
- `rd_data` input 8: byte read from the RTC.
- `bus_req` output 1: request to the bus driver (registered).
- `bus_out` output 8: address or data byte driven to the bus driver (registered).
- `fields` output NUM_FIELDS*8: committed field bank.
- `busy` output 1: high from `start` acceptance until commit or abort.
- `done` output 1: one-cycle pulse when a commit occurs.
- `bcd_err` output 1: set at commit if any captured byte failed the BCD check. Holds until the next commit.

## Operation
- **States:** IDLE, CMD, FIELD (with index `idx`), COMMIT. `mode` and `last` are latched at `start`; `last` = effective field count − 1.
- **Reset values:** state IDLE, `bus_req`=0, `bus_out`=IDLE_BYTE, `fields`=0, shadow=0, `busy`=0, `done`=0, `bcd_err`=0, `idx`=0.
- **IDLE:** `bus_out`=IDLE_BYTE. When `start`=1: go to CMD, `busy`=1, `bus_req`=1.
- **CMD:**
  - `dir_phase`: `bus_out` ← CMD_TMR if `mode`=1, else CMD_CLK.
  - `dat_phase`: `bus_out` ← CMD_DATA.
  - `step`: `idx` ← 0, go to FIELD.
- **FIELD:**
  - `dir_phase`: `bus_out` ← `addr_tbl[idx]`.
  - `dat_phase`: `shadow[idx]` ← `rd_data`; `err_acc` |= bcd_bad(`rd_data`).
  - `step`: if `idx`==`last`, go to COMMIT; otherwise `idx`++.
- **COMMIT:** lasts exactly one cycle.
  - `fields[i]` ← `shadow[i]` for i ≤ `last` only. Fields beyond `last` (timer mode) keep their previous values.
  - `bcd_err` ← `err_acc`; `done`=1; `busy`=0; go to IDLE.
- **Strobe priority:** if strobes coincide in one cycle, `dir_phase` > `dat_phase` > `step`. Only the highest-priority strobe acts.
- **`bus_req` in CMD/FIELD:** forced 0 for the single cycle following an accepted `step`, and 1 otherwise.
- **Clearing:** `err_acc` is cleared at `start` acceptance.
- **bcd_bad:** true when BCD_CHECK=1 and either nibble is > 9. With BCD_CHECK=0 it is always false.
- **`abort`:** highest priority, acts in any non-IDLE state. Next state IDLE; `bus_req`=0; `busy`=0; `bus_out`=IDLE_BYTE. No commit, no `done`; `fields` and `bcd_err` unchanged.
- **Ignored inputs:**
  - `start` while not in IDLE.
  - Strobes in IDLE or COMMIT.

## Timing
- `start` sampled at edge k: at edge k+1 state=CMD, `bus_req`=1, `busy`=1.
- Strobe sampled at edge k: the `bus_out`/shadow update is visible after edge k.
- Last `step` sampled at edge k: state=COMMIT after edge k. After edge k+1, `fields` are updated, `done`=1 for one cycle, `busy`=0, and state=IDLE.
- Because `done` and `busy`=0 appear in the IDLE cycle, `start` is accepted at earliest on edge k+2.
- Minimum burst is 3 + 3·(count) + 1 strobe-driven cycles. No internal timeout; the bus driver paces the burst.
- Reset mid-burst: all registers return to their reset values immediately; `fields` are cleared.

## Test plan
- **Clock burst:** NUM_FIELDS=6, `addr_tbl`={26,25,24,23,22,21}h, `mode`=0, each field fed `rd_data`=8'h1i, full strobe sequence.
  - `bus_out` sequence: F1, 01, 21, 22 … 26.
  - One `done` pulse; `fields`={16,15,14,13,12,11}h; `bcd_err`=0.
- **Timer burst:** preload `fields` via a clock burst, then `mode`=1 with TMR_FIELDS=3.
  - Command byte F2; exactly 3 field transfers.
  - `fields[2:0]` updated; `fields[5:3]` unchanged.
- **Atomicity and abort:** assert `abort` after field 2 `dat_phase`.
  - `fields` unchanged; no `done`; `bus_req`=0 and `bus_out`=FF the next cycle.
  - A following burst completes normally.
- **BCD check:** field 1 returns 8'h5A.
  - `bcd_err`=1 at commit; `fields[1]`=5A.
  - Next clean burst clears `bcd_err` to 0.
- **Strobe collision:** `dir_phase`, `dat_phase` and `step` all high in one FIELD cycle.
  - Only the address is loaded; `idx` unchanged.
  - `start` during busy is ignored.
- **Reset mid-burst:** assert `reset` in FIELD idx=3.
  - All outputs return to reset values asynchronously; state IDLE after release.
